// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: states, opcodes,
// ALU operations, immediate types and datapath mux selects.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEMADR    = 4'd2,
        S_MEMRD     = 4'd3,
        S_MEMWB     = 4'd4,
        S_MEMWR     = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALUWB     = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_JALR      = 4'd11,
        S_EXEC_LINK = 4'd12,
        S_UPPER     = 4'd13,
        S_TRAP      = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLT   = 4'd5;
    localparam logic [3:0] ALU_SLTU  = 4'd6;
    localparam logic [3:0] ALU_SLL   = 4'd7;
    localparam logic [3:0] ALU_SRL   = 4'd8;
    localparam logic [3:0] ALU_SRA   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;
    localparam logic [1:0] ALUOP_PASSB = 2'd3;

    localparam logic [2:0] EXT_I = 3'd0;
    localparam logic [2:0] EXT_S = 3'd1;
    localparam logic [2:0] EXT_B = 3'd2;
    localparam logic [2:0] EXT_U = 3'd3;
    localparam logic [2:0] EXT_J = 3'd4;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;
    localparam logic [1:0] SRCB_RS2   = 2'd0;
    localparam logic [1:0] SRCB_IMM   = 2'd1;
    localparam logic [1:0] SRCB_FOUR  = 2'd2;
    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_MEM    = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;

    // Immediate format is a pure function of the opcode.
    function automatic logic [2:0] ext_of(logic [6:0] op);
        case (op)
            OP_STORE:           return EXT_S;
            OP_BRANCH:          return EXT_B;
            OP_LUI, OP_AUIPC:   return EXT_U;
            OP_JAL:             return EXT_J;
            default:            return EXT_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decode from alu_op class and funct fields; combinational.
module mc_alu_decoder
    import multicycle_controller_pkg::*;
#(
    parameter int ALU_CTRL_W = 4
) (
    input  logic [1:0]            alu_op,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic                  op_5,
    output logic [ALU_CTRL_W-1:0] alu_control
);

    logic [3:0] ctrl;
    logic       unused_funct7;

    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_comb begin
        ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_SUB:   ctrl = ALU_SUB;
            ALUOP_PASSB: ctrl = ALU_PASSB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // op[5] separates R from I: addi never subtracts
                    3'b000:  ctrl = (op_5 && funct7[5]) ? ALU_SUB : ALU_ADD;
                    3'b001:  ctrl = ALU_SLL;
                    3'b010:  ctrl = ALU_SLT;
                    3'b011:  ctrl = ALU_SLTU;
                    3'b100:  ctrl = ALU_XOR;
                    3'b101:  ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  ctrl = ALU_OR;
                    default: ctrl = ALU_AND;
                endcase
            end
            default:     ctrl = ALU_ADD;
        endcase
    end

    assign alu_control = ALU_CTRL_W'(ctrl);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects and write enables from the registered state.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int ALU_CTRL_W = 4,
    parameter int EXT_W      = 3,
    parameter bit MEM_HS     = 1'b1,
    parameter bit TRAP_HALT  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic                  zero,
    input  logic                  lt,
    input  logic                  ltu,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  sel_addr,
    output logic                  ir_we,
    output logic                  pc_we,
    output logic                  rf_we,
    output logic                  dmem_we,
    output logic [1:0]            sel_alu_src_a,
    output logic [1:0]            sel_alu_src_b,
    output logic [1:0]            sel_result,
    output logic [EXT_W-1:0]      sel_ext,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  illegal_instr,
    output logic [3:0]            state_dbg
);

    state_t     state, state_nx;
    logic [1:0] alu_op;
    logic       ready, br_legal, br_taken;

    assign ready = MEM_HS ? mem_ready : 1'b1;

    always_comb begin
        br_legal = 1'b1;
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = zero;
            3'b001:  br_taken = !zero;
            3'b100:  br_taken = lt;
            3'b101:  br_taken = !lt;
            3'b110:  br_taken = ltu;
            3'b111:  br_taken = !ltu;
            default: br_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        mem_req       = 1'b0;
        sel_addr      = 1'b0;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        rf_we         = 1'b0;
        dmem_we       = 1'b0;
        sel_alu_src_a = SRCA_PC;
        sel_alu_src_b = SRCB_RS2;
        sel_result    = RES_ALUOUT;
        alu_op        = ALUOP_ADD;
        illegal_instr = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req       = 1'b1;
                sel_alu_src_b = SRCB_FOUR;
                sel_result    = RES_ALU;
                if (ready) begin
                    ir_we    = 1'b1;
                    pc_we    = 1'b1;
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculative branch/jump target lands in ALUOut.
                sel_alu_src_a = SRCA_OLDPC;
                sel_alu_src_b = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_nx = S_MEMADR;
                    OP_R:              state_nx = S_EXEC_R;
                    OP_I:              state_nx = S_EXEC_I;
                    OP_BRANCH:         state_nx = S_BRANCH;
                    OP_JAL:            state_nx = S_JAL;
                    OP_JALR:           state_nx = S_JALR;
                    OP_LUI, OP_AUIPC:  state_nx = S_UPPER;
                    default:           state_nx = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                sel_alu_src_a = SRCA_RS1;
                sel_alu_src_b = SRCB_IMM;
                state_nx      = (op == OP_STORE) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req  = 1'b1;
                sel_addr = 1'b1;
                if (ready) state_nx = S_MEMWB;
            end
            S_MEMWB: begin
                sel_result = RES_MEM;
                rf_we      = 1'b1;
                state_nx   = S_FETCH;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                sel_addr = 1'b1;
                dmem_we  = 1'b1;
                if (ready) state_nx = S_FETCH;
            end
            S_EXEC_R, S_EXEC_I: begin
                sel_alu_src_a = SRCA_RS1;
                sel_alu_src_b = (state == S_EXEC_I) ? SRCB_IMM : SRCB_RS2;
                alu_op        = ALUOP_FUNCT;
                state_nx      = S_ALUWB;
            end
            S_ALUWB: begin
                rf_we    = 1'b1;
                state_nx = S_FETCH;
            end
            S_BRANCH: begin
                sel_alu_src_a = SRCA_RS1;
                alu_op        = ALUOP_SUB;
                pc_we         = br_legal && br_taken;
                state_nx      = br_legal ? S_FETCH : S_TRAP;
            end
            S_JAL: begin
                // PC takes last cycle's ALUOut while the ALU forms the link.
                sel_alu_src_a = SRCA_OLDPC;
                sel_alu_src_b = SRCB_FOUR;
                pc_we         = 1'b1;
                state_nx      = S_ALUWB;
            end
            S_JALR: begin
                sel_alu_src_a = SRCA_RS1;
                sel_alu_src_b = SRCB_IMM;
                sel_result    = RES_ALU;
                pc_we         = 1'b1;
                state_nx      = S_EXEC_LINK;
            end
            S_EXEC_LINK: begin
                sel_alu_src_a = SRCA_OLDPC;
                sel_alu_src_b = SRCB_FOUR;
                state_nx      = S_ALUWB;
            end
            S_UPPER: begin
                sel_alu_src_a = SRCA_OLDPC;
                sel_alu_src_b = SRCB_IMM;
                alu_op        = (op == OP_LUI) ? ALUOP_PASSB : ALUOP_ADD;
                state_nx      = S_ALUWB;
            end
            S_TRAP: begin
                illegal_instr = 1'b1;
                state_nx      = TRAP_HALT ? S_TRAP : S_FETCH;
            end
            default: state_nx = S_FETCH;
        endcase
        // Reset quiets the datapath in the same cycle it is asserted.
        if (rst) begin
            mem_req       = 1'b0;
            sel_addr      = 1'b0;
            ir_we         = 1'b0;
            pc_we         = 1'b0;
            rf_we         = 1'b0;
            dmem_we       = 1'b0;
            sel_alu_src_a = SRCA_PC;
            sel_alu_src_b = SRCB_RS2;
            sel_result    = RES_ALUOUT;
            alu_op        = ALUOP_ADD;
            illegal_instr = 1'b0;
        end
    end

    mc_alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_dec (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7      (funct7),
        .op_5        (op[5]),
        .alu_control (alu_control)
    );

    assign sel_ext   = rst ? '0 : EXT_W'(ext_of(op));
    assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expectations queued with
// the stimulus, plus a random legal instruction stream with aggregate checks.
module tb_multicycle_controller;

    logic       clk = 1'b0, rst = 1'b1;
    logic [6:0] op, funct7;
    logic [2:0] funct3;
    logic       zero, lt, ltu, mem_ready;

    logic       mem_req, sel_addr, ir_we, pc_we, rf_we, dmem_we, illegal_instr;
    logic [1:0] sel_alu_src_a, sel_alu_src_b, sel_result;
    logic [2:0] sel_ext;
    logic [3:0] alu_control, state_dbg;

    logic       n_mem_req, n_sel_addr, n_ir_we, n_pc_we, n_rf_we, n_dmem_we, n_illegal;
    logic [1:0] n_src_a, n_src_b, n_sel_result;
    logic [2:0] n_sel_ext;
    logic [3:0] n_alu_control, n_state;

    multicycle_controller #(.TRAP_HALT(1'b1)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .mem_req(mem_req), .sel_addr(sel_addr), .ir_we(ir_we), .pc_we(pc_we),
        .rf_we(rf_we), .dmem_we(dmem_we), .sel_alu_src_a(sel_alu_src_a),
        .sel_alu_src_b(sel_alu_src_b), .sel_result(sel_result), .sel_ext(sel_ext),
        .alu_control(alu_control), .illegal_instr(illegal_instr), .state_dbg(state_dbg)
    );

    multicycle_controller #(.TRAP_HALT(1'b0)) dut_nh (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .mem_req(n_mem_req), .sel_addr(n_sel_addr), .ir_we(n_ir_we), .pc_we(n_pc_we),
        .rf_we(n_rf_we), .dmem_we(n_dmem_we), .sel_alu_src_a(n_src_a),
        .sel_alu_src_b(n_src_b), .sel_result(n_sel_result), .sel_ext(n_sel_ext),
        .alu_control(n_alu_control), .illegal_instr(n_illegal), .state_dbg(n_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        bit    rdy;
        int    st;
        int    we;    // {ir_we, pc_we, rf_we, dmem_we}
        bit    req;
        bit    ill;
        int    alu;   // -1: not checked
        int    sres;  // -1: not checked
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_pass = 0;

    task automatic chk(string tag, int obs, int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic void ex(string tag, bit rdy, int st, int we, bit req,
                               bit ill = 1'b0, int alu = -1, int sres = -1);
        exp_t e;
        e.tag = tag; e.rdy = rdy; e.st = st; e.we = we;
        e.req = req; e.ill = ill; e.alu = alu; e.sres = sres;
        sb.push_back(e);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(logic [31:0] w);
        op = w[6:0]; funct3 = w[14:12]; funct7 = w[31:25];
    endtask

    // Called one time unit after a rising edge; samples at the falling edge.
    task automatic drain;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            mem_ready = e.rdy;
            #4;
            chk({e.tag, "_st"}, state_dbg, e.st);
            chk({e.tag, "_we"}, {ir_we, pc_we, rf_we, dmem_we}, e.we);
            chk({e.tag, "_req"}, mem_req, e.req);
            chk({e.tag, "_ill"}, illegal_instr, e.ill);
            if (e.alu >= 0)  chk({e.tag, "_alu"}, alu_control, e.alu);
            if (e.sres >= 0) chk({e.tag, "_sres"}, sel_result, e.sres);
            step;
        end
    endtask

    task automatic do_reset(string tag);
        rst = 1'b1;
        #4;
        chk({tag, "_we"}, {ir_we, pc_we, rf_we, dmem_we}, 0);
        chk({tag, "_req"}, mem_req, 0);
        chk({tag, "_ill"}, illegal_instr, 0);
        step;
        chk({tag, "_st"}, state_dbg, 0);
        chk({tag, "_req2"}, mem_req, 0);
        chk({tag, "_dmem2"}, dmem_we, 0);
        rst = 1'b0;
    endtask

    // Fetch + decode preamble common to every instruction.
    function automatic void fd(string tag);
        ex({tag, "_F"}, 1, 0, 4'b1100, 1, 0, 0);
        ex({tag, "_D"}, 1, 1, 4'b0000, 0);
    endfunction

    task automatic branch(string tag, logic [31:0] w, bit z, bit l, bit lu, bit taken);
        set_instr(w); zero = z; lt = l; ltu = lu;
        fd(tag);
        ex({tag, "_BR"}, 1, 9, taken ? 4'b0100 : 4'b0000, 0, 0, 1);
        drain;
    endtask

    localparam int N_RAND = 10000;
    localparam int BUDGET = 90000;

    initial begin
        logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        int         bf3 [6] = '{0, 1, 4, 5, 6, 7};
        int n_pick = 0, cyc = 0;
        int rf_exp = 0, rf_obs = 0, st_exp = 0, st_obs = 0, tk_exp = 0, tk_obs = 0;
        int bad_oh = 0, bad_st = 0;
        bit picked = 1'b0;

        mem_ready = 1'b1; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
        set_instr(32'h00000013);
        rst = 1'b1;
        step; step;
        #4;
        chk("rst_we", {ir_we, pc_we, rf_we, dmem_we}, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_ill", illegal_instr, 0);
        chk("rst_srca", sel_alu_src_a, 0);
        chk("rst_srcb", sel_alu_src_b, 0);
        chk("rst_sres", sel_result, 0);
        chk("rst_st", state_dbg, 0);
        step;
        rst = 1'b0;

        // add x3,x1,x2
        set_instr(32'h002081B3);
        fd("add");
        ex("add_EX", 1, 6, 4'b0000, 0, 0, 0);
        ex("add_WB", 1, 8, 4'b0010, 0, 0, -1, 0);
        drain;

        set_instr(32'h402081B3);  // sub
        fd("sub"); ex("sub_EX", 1, 6, 0, 0, 0, 1); ex("sub_WB", 1, 8, 4'b0010, 0);
        drain;
        set_instr(32'h4030D293);  // srai
        fd("srai"); ex("srai_EX", 1, 7, 0, 0, 0, 9); ex("srai_WB", 1, 8, 4'b0010, 0);
        drain;
        set_instr(32'h40008093);  // addi with imm bit 10 set: still ADD
        fd("addi"); ex("addi_EX", 1, 7, 0, 0, 0, 0); ex("addi_WB", 1, 8, 4'b0010, 0);
        drain;

        // lw x5,8(x1) with two stall cycles in MEMRD
        set_instr(32'h0080A283);
        fd("lw");
        ex("lw_ADR", 1, 2, 4'b0000, 0, 0, 0);
        ex("lw_RD0", 0, 3, 4'b0000, 1);
        ex("lw_RD1", 0, 3, 4'b0000, 1);
        ex("lw_RD2", 1, 3, 4'b0000, 1);
        ex("lw_WB", 1, 4, 4'b0010, 0, 0, -1, 1);
        drain;

        branch("bne_nt",  32'h00209463, 1, 0, 0, 0);
        branch("bltu_t",  32'h0020E463, 0, 0, 1, 1);
        branch("beq_nt",  32'h00208463, 0, 0, 0, 0);
        branch("bge_t",   32'h0020D463, 0, 0, 0, 1);
        branch("bge_nt",  32'h0020D463, 0, 1, 0, 0);

        set_instr(32'h008000EF);  // jal
        fd("jal"); ex("jal_J", 1, 10, 4'b0100, 0); ex("jal_WB", 1, 8, 4'b0010, 0);
        drain;
        set_instr(32'h000080E7);  // jalr
        fd("jalr");
        ex("jalr_J", 1, 11, 4'b0100, 0, 0, 0, 2);
        ex("jalr_L", 1, 12, 4'b0000, 0);
        ex("jalr_WB", 1, 8, 4'b0010, 0);
        drain;
        set_instr(32'h123452B7);  // lui
        fd("lui"); ex("lui_U", 1, 13, 0, 0, 0, 10); ex("lui_WB", 1, 8, 4'b0010, 0);
        drain;
        set_instr(32'h12345297);  // auipc
        fd("auipc"); ex("auipc_U", 1, 13, 0, 0, 0, 0); ex("auipc_WB", 1, 8, 4'b0010, 0);
        drain;
        set_instr(32'h0050A423);  // sw
        fd("sw"); ex("sw_ADR", 1, 2, 0, 0); ex("sw_WR", 1, 5, 4'b0001, 1);
        drain;

        // Illegal opcode: halting instance parks, non-halting one refetches.
        set_instr(32'h0000007F);
        fd("ill");
        drain;
        for (int i = 0; i < 10; i++) begin
            mem_ready = 1'b1;
            #4;
            chk("trap_st", state_dbg, 14);
            chk("trap_ill", illegal_instr, 1);
            chk("trap_we", {ir_we, pc_we, rf_we, dmem_we, mem_req}, 0);
            if (i == 0) begin
                chk("nh_trap_st", n_state, 14);
                chk("nh_trap_ill", n_illegal, 1);
            end
            if (i == 1) begin
                chk("nh_refetch_st", n_state, 0);
                chk("nh_refetch_ill", n_illegal, 0);
            end
            step;
        end
        do_reset("trap_rst");

        // Branch with reserved funct3 traps.
        set_instr(32'h0020A463);
        fd("brill");
        ex("brill_BR", 1, 9, 4'b0000, 0);
        ex("brill_TRAP", 1, 14, 4'b0000, 0, 1);
        drain;
        do_reset("brill_rst");

        // Store stalled in MEMWR is abandoned by reset.
        set_instr(32'h0050A423);
        fd("swr"); ex("swr_ADR", 1, 2, 0, 0); ex("swr_WR", 0, 5, 4'b0001, 1);
        drain;
        mem_ready = 1'b0;
        do_reset("swr_rst");

        // Random legal instruction stream.
        while (1) begin
            if (state_dbg == 0 && !picked) begin
                int c;
                if (n_pick == N_RAND) break;
                c = $urandom_range(0, 8);
                op = ops[c];
                funct3 = 3'($urandom_range(0, 7));
                funct7 = $urandom_range(0, 1) ? 7'h20 : 7'h00;
                zero = 1'($urandom_range(0, 1));
                lt = 1'($urandom_range(0, 1));
                ltu = 1'($urandom_range(0, 1));
                if (c == 2 || c == 3) funct3 = 3'b010;
                if (c == 4) begin
                    funct3 = 3'(bf3[$urandom_range(0, 5)]);
                    case (funct3)
                        3'd0: tk_exp += int'(zero);
                        3'd1: tk_exp += int'(!zero);
                        3'd4: tk_exp += int'(lt);
                        3'd5: tk_exp += int'(!lt);
                        3'd6: tk_exp += int'(ltu);
                        default: tk_exp += int'(!ltu);
                    endcase
                end else if (c == 3) st_exp++;
                else rf_exp++;
                picked = 1'b1;
                n_pick++;
            end else if (state_dbg != 0) begin
                picked = 1'b0;
            end
            mem_ready = ($urandom_range(0, 3) != 0);
            #4;
            if (!$onehot0({rf_we, dmem_we, ir_we})) bad_oh++;
            if (state_dbg > 13) bad_st++;
            if (rf_we) rf_obs++;
            if (dmem_we && mem_ready) st_obs++;
            if (state_dbg == 9 && pc_we) tk_obs++;
            cyc++;
            if (cyc > BUDGET) break;
            step;
        end
        chk("rand_budget", int'(cyc <= BUDGET), 1);
        chk("rand_count", n_pick, N_RAND);
        chk("rand_onehot", bad_oh, 0);
        chk("rand_state", bad_st, 0);
        chk("rand_rf_writes", rf_obs, rf_exp);
        chk("rand_stores", st_obs, st_exp);
        chk("rand_taken", tk_obs, tk_exp);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
